// File: rtl/addsub_sat_pipe.sv
// Two-stage pipelined signed add/subtract with optional saturation and N/Z/V flags.
// Low half is summed in stage 1, high half plus flags/saturation in stage 2.
module addsub_sat_pipe #(
   parameter int          WIDTH   = 16,
   parameter int unsigned SAT_DEF = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   input  logic             sat_en,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             ovfl,
   output logic             neg,
   output logic             zero
);

   localparam int HALF = WIDTH / 2;
   localparam int NBLK = HALF / 4;

   if (WIDTH < 8 || (WIDTH % 8) != 0 || SAT_DEF > 1) begin : g_bad_param
      $error("addsub_sat_pipe: WIDTH must be a multiple of 8 (>= 8), SAT_DEF must be 0 or 1");
   end

   // 4-bit carry-lookahead blocks, block carries chained from low to high.
   function automatic logic [HALF:0] cla_add(input logic [HALF-1:0] x,
                                             input logic [HALF-1:0] y,
                                             input logic            cin);
      logic [HALF-1:0] g, p, s;
      logic [3:0]      gb, pb;
      logic [4:0]      cb;
      logic            c;
      g = x & y;
      p = x ^ y;
      s = '0;
      c = cin;
      for (int k = 0; k < NBLK; k++) begin
         gb    = g[4*k +: 4];
         pb    = p[4*k +: 4];
         cb[0] = c;
         cb[1] = gb[0] | (pb[0] & c);
         cb[2] = gb[1] | (pb[1] & gb[0]) | (pb[1] & pb[0] & c);
         cb[3] = gb[2] | (pb[2] & gb[1]) | (pb[2] & pb[1] & gb[0])
               | (pb[2] & pb[1] & pb[0] & c);
         cb[4] = gb[3] | (pb[3] & gb[2]) | (pb[3] & pb[2] & gb[1])
               | (pb[3] & pb[2] & pb[1] & gb[0]) | (&pb & c);
         s[4*k +: 4] = pb ^ cb[3:0];
         c = cb[4];
      end
      return {c, s};
   endfunction

   // Stage 1 registers
   logic            s1_valid_q, s1_valid_d;
   logic [HALF-1:0] s1_lo_q,    s1_lo_d;
   logic            s1_cmid_q,  s1_cmid_d;
   logic [HALF-1:0] s1_ahi_q,   s1_ahi_d;
   logic [HALF-1:0] s1_bhi_q,   s1_bhi_d;
   logic            s1_sat_q,   s1_sat_d;

   // Stage 2 registers (drive the outputs directly)
   logic             s2_valid_q, s2_valid_d;
   logic [WIDTH-1:0] s2_res_q,   s2_res_d;
   logic             s2_ovfl_q,  s2_ovfl_d;
   logic             s2_neg_q,   s2_neg_d;
   logic             s2_zero_q,  s2_zero_d;

   logic             s2_adv, s1_adv, in_fire;
   logic [WIDTH-1:0] binv;
   logic [HALF:0]    lo_sum;
   logic [HALF-1:0]  hi_sum;
   logic             hi_cout_unused;
   logic [WIDTH-1:0] raw, sat_val, res_c;
   logic             a_msb, b_msb, ovfl_c;

   assign s2_adv   = !s2_valid_q | out_ready;
   assign s1_adv   = s1_valid_q & s2_adv;
   assign in_ready = !s1_valid_q | s2_adv;
   assign in_fire  = in_valid & in_ready;

   assign binv   = sub ? ~b : b;
   assign lo_sum = cla_add(a[HALF-1:0], binv[HALF-1:0], sub);

   assign {hi_cout_unused, hi_sum} = cla_add(s1_ahi_q, s1_bhi_q, s1_cmid_q);
   assign raw     = {hi_sum, s1_lo_q};
   assign a_msb   = s1_ahi_q[HALF-1];
   assign b_msb   = s1_bhi_q[HALF-1];
   assign ovfl_c  = (a_msb ~^ b_msb) & (raw[WIDTH-1] ^ a_msb);
   assign sat_val = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
   assign res_c   = (s1_sat_q & ovfl_c) ? sat_val : raw;

   always_comb begin
      // NOTE: every _d starts as its _q so no path leaves a variable unassigned (no latches).
      s1_valid_d = s1_valid_q;
      s1_lo_d    = s1_lo_q;
      s1_cmid_d  = s1_cmid_q;
      s1_ahi_d   = s1_ahi_q;
      s1_bhi_d   = s1_bhi_q;
      s1_sat_d   = s1_sat_q;
      s2_valid_d = s2_valid_q;
      s2_res_d   = s2_res_q;
      s2_ovfl_d  = s2_ovfl_q;
      s2_neg_d   = s2_neg_q;
      s2_zero_d  = s2_zero_q;

      if (in_fire) begin
         s1_valid_d = 1'b1;
         s1_lo_d    = lo_sum[HALF-1:0];
         s1_cmid_d  = lo_sum[HALF];
         s1_ahi_d   = a[WIDTH-1:HALF];
         s1_bhi_d   = binv[WIDTH-1:HALF];
         s1_sat_d   = sat_en;
      end else if (s1_adv) begin
         s1_valid_d = 1'b0;
      end

      if (s2_adv) begin
         s2_valid_d = s1_valid_q;
      end
      if (s1_adv) begin
         s2_res_d  = res_c;
         s2_ovfl_d = ovfl_c;
         s2_neg_d  = res_c[WIDTH-1];
         s2_zero_d = (res_c == '0);
      end
   end

   // NOTE: state updates use non-blocking assignments so all registers see pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_lo_q    <= '0;
         s1_cmid_q  <= 1'b0;
         s1_ahi_q   <= '0;
         s1_bhi_q   <= '0;
         s1_sat_q   <= 1'b0;
         s2_valid_q <= 1'b0;
         s2_res_q   <= '0;
         s2_ovfl_q  <= 1'b0;
         s2_neg_q   <= 1'b0;
         s2_zero_q  <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_lo_q    <= s1_lo_d;
         s1_cmid_q  <= s1_cmid_d;
         s1_ahi_q   <= s1_ahi_d;
         s1_bhi_q   <= s1_bhi_d;
         s1_sat_q   <= s1_sat_d;
         s2_valid_q <= s2_valid_d;
         s2_res_q   <= s2_res_d;
         s2_ovfl_q  <= s2_ovfl_d;
         s2_neg_q   <= s2_neg_d;
         s2_zero_q  <= s2_zero_d;
      end
   end

   assign out_valid = s2_valid_q;
   assign result    = s2_res_q;
   assign ovfl      = s2_ovfl_q;
   assign neg       = s2_neg_q;
   assign zero      = s2_zero_q;

endmodule

// File: tb/tb_addsub_sat_pipe.sv
// Bench for addsub_sat_pipe: 16- and 32-bit instances share handshake controls,
// results are scored against an integer-arithmetic saturating model.
module tb_addsub_sat_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, in_valid, sub, sat_en, out_ready;
   logic [15:0] a16, b16;
   logic [31:0] a32, b32;

   logic        in_ready16, out_valid16, ovfl16, neg16, zero16;
   logic [15:0] result16;
   logic        in_ready32, out_valid32, ovfl32, neg32, zero32;
   logic [31:0] result32;

   addsub_sat_pipe #(.WIDTH(16), .SAT_DEF(1)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready16),
      .a(a16), .b(b16), .sub(sub), .sat_en(sat_en),
      .out_valid(out_valid16), .out_ready(out_ready), .result(result16),
      .ovfl(ovfl16), .neg(neg16), .zero(zero16));

   addsub_sat_pipe #(.WIDTH(32), .SAT_DEF(1)) u_dut32 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
      .a(a32), .b(b32), .sub(sub), .sat_en(sat_en),
      .out_valid(out_valid32), .out_ready(out_ready), .result(result32),
      .ovfl(ovfl32), .neg(neg32), .zero(zero32));

   typedef struct {
      logic [31:0] res;
      logic        ovfl;
      logic        neg;
      logic        zero;
   } exp_t;

   exp_t q16[$];
   exp_t q32[$];

   int n_checks = 0;
   int n_errors = 0;
   int n_in     = 0;
   int n_out    = 0;
   logic        last_in_ready;
   logic [15:0] last_res16;
   logic        last_ovfl16, last_neg16, last_zero16;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Exact integer result, then clamp or wrap to w bits.
   function automatic exp_t model(input int w, input longint sa, input longint sb,
                                  input bit s, input bit sat);
      exp_t        e;
      longint      mx, mn, full, r;
      logic [31:0] mask;
      mx   = (longint'(1) <<< (w - 1)) - 1;
      mn   = -(longint'(1) <<< (w - 1));
      full = s ? sa - sb : sa + sb;
      e.ovfl = (full > mx) || (full < mn);
      if (sat && e.ovfl) r = (full > mx) ? mx : mn;
      else               r = full;
      mask   = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
      e.res  = 32'(r) & mask;
      e.neg  = e.res[w-1];
      e.zero = (e.res == 32'd0);
      return e;
   endfunction

   function automatic logic [15:0] rnd16();
      case ($urandom_range(0, 6))
         0:       return 16'h0000;
         1:       return 16'h0001;
         2:       return 16'h7FFF;
         3:       return 16'h8000;
         4:       return 16'hFFFF;
         default: return 16'($urandom);
      endcase
   endfunction

   function automatic logic [31:0] rnd32();
      case ($urandom_range(0, 6))
         0:       return 32'h0000_0000;
         1:       return 32'h0000_0001;
         2:       return 32'h7FFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'hFFFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   task automatic rand_beat();
      a16    = rnd16();
      b16    = rnd16();
      a32    = rnd32();
      b32    = rnd32();
      sub    = 1'($urandom_range(0, 1));
      sat_en = 1'($urandom_range(0, 1));
   endtask

   // One clock: inputs already set after a falling edge; sample, score, advance.
   task automatic step();
      exp_t e;
      #1;
      last_in_ready = in_ready16;
      if (rst_n && in_valid && in_ready16) begin
         q16.push_back(model(16, longint'($signed(a16)), longint'($signed(b16)), sub, sat_en));
         q32.push_back(model(32, longint'($signed(a32)), longint'($signed(b32)), sub, sat_en));
         n_in++;
      end
      if (rst_n && out_valid16 && out_ready) begin
         check("beat_expected", 64'(q16.size() != 0), 64'd1);
         check("out_valid32", 64'(out_valid32), 64'd1);
         if (q16.size() != 0 && q32.size() != 0) begin
            e = q16.pop_front();
            check("res16",  64'(result16), 64'(e.res));
            check("ovfl16", 64'(ovfl16),   64'(e.ovfl));
            check("neg16",  64'(neg16),    64'(e.neg));
            check("zero16", 64'(zero16),   64'(e.zero));
            e = q32.pop_front();
            check("res32",  64'(result32), 64'(e.res));
            check("ovfl32", 64'(ovfl32),   64'(e.ovfl));
            check("neg32",  64'(neg32),    64'(e.neg));
            check("zero32", 64'(zero32),   64'(e.zero));
         end
         last_res16  = result16;
         last_ovfl16 = ovfl16;
         last_neg16  = neg16;
         last_zero16 = zero16;
         n_out++;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 20 && q16.size() != 0; i++) step();
      check("drain_empty", 64'(q16.size()), 64'd0);
   endtask

   task automatic directed(input string tag, input logic [15:0] a_v, input logic [15:0] b_v,
                           input bit s, input bit sat, input logic [15:0] er,
                           input bit eo, input bit en, input bit ez);
      int base;
      base      = n_out;
      a16       = a_v;
      b16       = b_v;
      a32       = rnd32();
      b32       = rnd32();
      sub       = s;
      sat_en    = sat;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 10 && n_out == base; i++) step();
      check({tag, "_arrived"}, 64'(n_out - base), 64'd1);
      check({tag, "_res"},  64'(last_res16),  64'(er));
      check({tag, "_ovfl"}, 64'(last_ovfl16), 64'(eo));
      check({tag, "_neg"},  64'(last_neg16),  64'(en));
      check({tag, "_zero"}, 64'(last_zero16), 64'(ez));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int base_in, base_out, idx;
      logic [15:0] bp_a[4];
      logic [15:0] bp_b[4];

      // Reset with in_valid held high
      rst_n     = 1'b0;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      rand_beat();
      repeat (3) begin
         @(negedge clk);
         check("rst_out_valid", 64'(out_valid16), 64'd0);
         check("rst_result",    64'(result16),    64'd0);
         check("rst_flags",     64'({ovfl16, neg16, zero16}), 64'd0);
      end
      rst_n = 1'b1;
      step();
      in_valid = 1'b0;
      check("lat_in_ready", 64'(last_in_ready), 64'd1);
      check("lat_cycle1_out_valid", 64'(out_valid16), 64'd0);
      step();
      check("lat_cycle2_out_valid", 64'(out_valid16), 64'd1);
      drain();

      // Directed boundary cases (16-bit expectations written out by hand)
      directed("add_sat",    16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b0, 1'b0);
      directed("add_wrap",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0);
      directed("sub_sat",    16'h8000, 16'h0001, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0);
      directed("sub_zero",   16'h0005, 16'h0005, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);
      directed("sub_min_s",  16'h0001, 16'h8000, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b0, 1'b0);
      directed("sub_min_w",  16'h0001, 16'h8000, 1'b1, 1'b0, 16'h8001, 1'b1, 1'b1, 1'b0);
      directed("neg_sat",    16'h8000, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0);
      directed("carry_mid",  16'h00FF, 16'h0001, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0, 1'b0);

      // Backpressure: 4 beats, out_ready low during cycles 2-5
      for (int i = 0; i < 4; i++) begin
         bp_a[i] = 16'($urandom);
         bp_b[i] = 16'($urandom);
      end
      base_in  = n_in;
      base_out = n_out;
      idx      = 0;
      for (int cyc = 1; cyc <= 12; cyc++) begin
         in_valid = (idx < 4);
         if (idx < 4) begin
            a16    = bp_a[idx];
            b16    = bp_b[idx];
            a32    = rnd32();
            b32    = rnd32();
            sub    = 1'($urandom_range(0, 1));
            sat_en = 1'($urandom_range(0, 1));
         end
         out_ready = !(cyc >= 2 && cyc <= 5);
         step();
         idx = n_in - base_in;
         if (cyc >= 3 && cyc <= 5) begin
            check("bp_in_ready_low", 64'(last_in_ready), 64'd0);
         end
         if (cyc >= 2 && cyc <= 5) begin
            check("bp_out_valid_hold", 64'(out_valid16), 64'd1);
            check("bp_result_hold", 64'(result16), 64'(q16[0].res));
         end
         if (cyc == 5) check("bp_accepted_two", 64'(n_in - base_in), 64'd2);
      end
      drain();
      check("bp_all_in",  64'(n_in - base_in),   64'd4);
      check("bp_all_out", 64'(n_out - base_out), 64'd4);

      // Full throughput: 100 back-to-back random beats
      base_in   = n_in;
      base_out  = n_out;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 100; i++) begin
         rand_beat();
         step();
         check("tp_in_ready", 64'(last_in_ready), 64'd1);
      end
      check("tp_accepted", 64'(n_in - base_in),   64'd100);
      check("tp_emitted",  64'(n_out - base_out), 64'd98);
      in_valid = 1'b0;
      step();
      step();
      check("tp_total_out", 64'(n_out - base_out), 64'd100);
      drain();

      // Mid-stream reset with two beats in flight
      in_valid = 1'b1;
      rand_beat();
      step();
      rand_beat();
      step();
      in_valid = 1'b0;
      check("mr_pre_out_valid", 64'(out_valid16), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check("mr_async_out_valid16", 64'(out_valid16), 64'd0);
      check("mr_async_out_valid32", 64'(out_valid32), 64'd0);
      check("mr_async_result", 64'(result16), 64'd0);
      q16.delete();
      q32.delete();
      @(negedge clk);
      rst_n     = 1'b1;
      base_out  = n_out;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check("mr_no_stale", 64'(out_valid16), 64'd0);
      end
      check("mr_no_output", 64'(n_out - base_out), 64'd0);
      directed("post_rst", 16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0);
      check("final_q32_empty", 64'(q32.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
